// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Default geometry constants; the modules recompute widths from their own parameters.
package dcache_pkg;

  localparam int unsigned DC_LINE_WORDS = 4;
  localparam int unsigned DC_NUM_LINES  = 64;
  localparam int unsigned DC_ADDR_W     = 32;
  localparam int unsigned DC_WORD_W     = $clog2(DC_LINE_WORDS);
  localparam int unsigned DC_INDEX_W    = $clog2(DC_NUM_LINES);
  localparam int unsigned DC_TAG_W      = DC_ADDR_W - 2 - DC_WORD_W - DC_INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2,
    WRITE  = 2'd3
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for dcache_ctrl: synchronous writes, asynchronous read,
// per-line valid clear. Only the valid bits are reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DC_NUM_LINES,
  parameter int unsigned TAG_W      = DC_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_line_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
  output logic                          rd_valid_o,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic [31:0]                   rd_data_o,
  input  logic                          data_we_i,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_line_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          tag_we_i,
  input  logic [$clog2(NUM_LINES)-1:0]  tag_line_i,
  input  logic [TAG_W-1:0]              tag_i,
  input  logic                          vclr_i,
  input  logic [$clog2(NUM_LINES)-1:0]  vclr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (vclr_i)   valid_q[vclr_line_i] <= 1'b0;
      if (tag_we_i) valid_q[tag_line_i]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i)  tag_q[tag_line_i] <= tag_i;
    if (data_we_i) data_q[{wr_line_i, wr_word_i}] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_line_i];
  assign rd_tag_o   = tag_q[rd_line_i];
  assign rd_data_o  = data_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DC_NUM_LINES,
  parameter int unsigned ADDR_W     = DC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [3:0]        cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              data_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_wack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - 2 - WORD_W - LINE_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  state_e            state_q;
  logic [WORD_W-1:0] cnt_q, req_word_q;
  logic [LINE_W-1:0] req_line_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, rdata_q;
  logic [3:0]        mem_wstrb_q;

  logic [WORD_W-1:0] cpu_word;
  logic [LINE_W-1:0] cpu_line;
  logic [TAG_W-1:0]  cpu_tag;
  logic              unused_byte_offset;

  assign cpu_word           = cpu_addr[2 +: WORD_W];
  assign cpu_line           = cpu_addr[2 + WORD_W +: LINE_W];
  assign cpu_tag            = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_offset = ^cpu_addr[1:0];

  logic              in_idle, is_store, hit;
  logic              read_hit, read_miss, refill_beat, store_ack;
  logic [LINE_W-1:0] rd_line;
  logic [WORD_W-1:0] rd_word;
  logic [TAG_W-1:0]  cmp_tag, rd_tag;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              data_we;
  logic [WORD_W-1:0] wr_word;
  logic [31:0]       wr_data;

  // The lookup port follows the CPU in IDLE and the latched request otherwise.
  assign in_idle  = (state_q == IDLE);
  assign is_store = |cpu_write;
  assign rd_line  = in_idle ? cpu_line : req_line_q;
  assign rd_word  = in_idle ? cpu_word : req_word_q;
  assign cmp_tag  = in_idle ? cpu_tag  : req_tag_q;
  assign hit      = rd_valid && (rd_tag == cmp_tag);

  assign read_hit    = in_idle && cpu_read && !is_store && hit;
  assign read_miss   = in_idle && cpu_read && !is_store && !hit;
  assign refill_beat = (state_q == REFILL) && mem_rvalid;
  assign store_ack   = (state_q == WRITE) && mem_wack;

  assign data_we = refill_beat || (store_ack && hit);
  assign wr_word = refill_beat ? cnt_q : req_word_q;
  assign wr_data = refill_beat ? mem_rdata : byte_merge(rd_data, mem_wdata_q, mem_wstrb_q);

  dcache_array #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_line_i  (rd_line),
    .rd_word_i  (rd_word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .data_we_i  (data_we),
    .wr_line_i  (req_line_q),
    .wr_word_i  (wr_word),
    .wr_data_i  (wr_data),
    .tag_we_i   (refill_beat && (cnt_q == LAST_WORD)),
    .tag_line_i (req_line_q),
    .tag_i      (req_tag_q),
    .vclr_i     (read_miss),
    .vclr_line_i(cpu_line)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_word_q  <= '0;
      req_line_q  <= '0;
      req_tag_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_store) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= cpu_wdata;
            mem_wstrb_q <= cpu_write;
            req_word_q  <= cpu_word;
            req_line_q  <= cpu_line;
            req_tag_q   <= cpu_tag;
          end else if (read_miss) begin
            state_q    <= REFILL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {cpu_tag, cpu_line, {WORD_W{1'b0}}, 2'b00};
            cnt_q      <= '0;
            req_word_q <= cpu_word;
            req_line_q <= cpu_line;
            req_tag_q  <= cpu_tag;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            if (cnt_q == req_word_q) rdata_q <= mem_rdata;
            if (cnt_q == LAST_WORD) begin
              cnt_q     <= '0;
              mem_req_q <= 1'b0;
              state_q   <= RESP;
            end else begin
              cnt_q <= cnt_q + WORD_W'(1);
            end
          end
        end
        RESP: state_q <= IDLE;
        WRITE: begin
          if (mem_wack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hits answer combinationally; misses answer from the captured word in RESP.
  assign data_ready = read_hit || (state_q == RESP) || store_ack;
  assign cpu_rdata  = read_hit ? rd_data : rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (read_hit)  hits_q   <= hits_q + 32'd1;
      if (read_miss) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus randomized bench for dcache_ctrl, checked against a behavioural
// cache/memory model. Stat counters are checked when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;

  localparam int unsigned LW   = 4;
  localparam int unsigned NL   = 64;
  localparam int unsigned AW   = 32;
  localparam int unsigned SPAN = 4 * LW * NL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_read = 1'b0;
  logic [3:0]  cpu_write = 4'h0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        data_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_wack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.LINE_WORDS(LW), .NUM_LINES(NL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .data_ready(data_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: per-line valid/tag/words plus a sparse backing memory.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  logic [31:0] m_data  [NL][LW];
  logic [31:0] mem     [int unsigned];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  function automatic int unsigned f_word(input int unsigned a); return (a / 4) % LW; endfunction
  function automatic int unsigned f_line(input int unsigned a); return (a / (4 * LW)) % NL; endfunction
  function automatic int unsigned f_tag (input int unsigned a); return a / SPAN; endfunction

  function automatic logic [31:0] mem_rd(input int unsigned wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int unsigned gap_max);
    int unsigned ln, wd, tg;
    logic [31:0] base;
    bit hit;
    ln   = f_line(addr);
    wd   = f_word(addr);
    tg   = f_tag(addr);
    base = addr & ~(4 * LW - 1);
    hit  = m_valid[ln] && (m_tag[ln] == tg);
    @(negedge clk);
    cpu_read = 1'b1; cpu_write = 4'h0; cpu_addr = addr; cpu_wdata = $urandom;
    #1;
    if (hit) begin
      exp_hits++;
      chk("hit_ready", {31'd0, data_ready}, 32'd1);
      chk("hit_rdata", cpu_rdata, m_data[ln][wd]);
      $display("read  %08h hit  data=%08h", addr, cpu_rdata);
      @(negedge clk);
      cpu_read = 1'b0;
      #1;
      chk("hit_noreq", {31'd0, mem_req}, 32'd0);
    end else begin
      exp_misses++;
      chk("miss_ready", {31'd0, data_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("miss_req", {31'd0, mem_req}, 32'd1);
      chk("miss_we", {31'd0, mem_we}, 32'd0);
      chk("miss_addr", mem_addr, base);
      for (int b = 0; b < int'(LW); b++) begin
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = mem_rd(base + 4 * b);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        #1;
        if (b < int'(LW) - 1) begin
          chk("burst_addr", mem_addr, base);
          chk("burst_ready", {31'd0, data_ready}, 32'd0);
        end
      end
      m_valid[ln] = 1'b1;
      m_tag[ln]   = tg;
      for (int w = 0; w < int'(LW); w++) m_data[ln][w] = mem_rd(base + 4 * w);
      chk("resp_ready", {31'd0, data_ready}, 32'd1);
      chk("resp_rdata", cpu_rdata, m_data[ln][wd]);
      chk("resp_req", {31'd0, mem_req}, 32'd0);
      $display("read  %08h miss data=%08h", addr, cpu_rdata);
      @(negedge clk);
      cpu_read = 1'b0;
      #1;
      chk("resp_once", {31'd0, data_ready}, 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                          input bit with_read, input int unsigned gap_max);
    int unsigned ln;
    logic [31:0] wa;
    bit hit;
    ln  = f_line(addr);
    wa  = addr & ~32'd3;
    hit = m_valid[ln] && (m_tag[ln] == f_tag(addr));
    @(negedge clk);
    cpu_read = with_read; cpu_write = be; cpu_addr = addr; cpu_wdata = wd;
    #1;
    chk("st_ready0", {31'd0, data_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, wa);
    chk("st_wdata", mem_wdata, wd);
    chk("st_wstrb", {28'd0, mem_wstrb}, {28'd0, be});
    repeat ($urandom_range(gap_max, 0)) begin
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      @(negedge clk);
      #1;
      chk("st_hold", mem_addr, wa);
    end
    mem_wack = 1'b1;
    #1;
    chk("st_ready", {31'd0, data_ready}, 32'd1);
    $display("write %08h be=%h data=%08h rd=%0d hit=%0d", addr, be, wd, with_read, hit);
    @(negedge clk);
    mem_wack = 1'b0; cpu_write = 4'h0; cpu_read = 1'b0;
    #1;
    chk("st_done_req", {31'd0, mem_req}, 32'd0);
    chk("st_once", {31'd0, data_ready}, 32'd0);
    mem[wa] = merge(mem_rd(wa), wd, be);
    if (hit) m_data[ln][f_word(addr)] = merge(m_data[ln][f_word(addr)], wd, be);
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    chk({tag, "_hits"}, stat_hits, exp_hits);
    chk({tag, "_misses"}, stat_misses, exp_misses);
`else
    $display("stats %s skipped", tag);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_ready"}, {31'd0, data_ready}, 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
    for (int w = 0; w < 4; w++) mem[32'h100 + 4 * w] = 32'hA0 + w;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Cold miss then zero-wait hit.
    do_read(32'h0000_0104, 1);
    do_read(32'h0000_0104, 0);
    check_stats("after_hit");

    // Store merge into a resident line.
    do_write(32'h0000_0104, 32'h1234_5678, 4'b0011, 1'b0, 2);
    do_read(32'h0000_0104, 0);

    // No write-allocate.
    do_write(32'h0000_2000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1);
    do_read(32'h0000_2000, 1);

    // Conflict eviction.
    do_read(32'h0000_0100, 0);
    do_read(32'h0000_0100 + SPAN, 2);
    do_read(32'h0000_0100, 1);

    // Simultaneous read and store: store wins.
    do_write(32'h0000_0108, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1);
    do_read(32'h0000_0108, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int unsigned op;
      a  = $urandom_range(2, 0) * SPAN + $urandom_range(3, 0) * (4 * LW)
         + $urandom_range(3, 0) * 4 + $urandom_range(3, 0);
      op = $urandom_range(9, 0);
      if (op < 6) do_read(a, 2);
      else        do_write(a, $urandom, 4'($urandom_range(15, 1)), op == 9, 2);
    end
    check_stats("random");

    // Reset in the middle of a refill, after two beats.
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h0000_0540;
    @(negedge clk);
    #1;
    chk("abort_req", {31'd0, mem_req}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_rd(32'h540 + 4 * b);
      @(negedge clk);
    end
    mem_rvalid = 1'b0; rst = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    $display("reset during refill of 00000540");
    for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    do_read(32'h0000_0540, 1);
    do_read(32'h0000_0104, 0);
    check_stats("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
